// File: rtl/rope_hook_if.sv
// Hook/rope controller bus: game-side controls in, hook pose and catch reports out.
// Combinational bundle; no latency of its own.
// No backpressure; draw_busy freezes motion inside the controller.
//
// master: the rope_hook_fsm side (drives degree, rope_len, state, catch report).
// slave : the game side (drives enable, draw_busy, keys, collision inputs).
interface rope_hook_if #(
    parameter int DEG_W    = 10,
    parameter int LEN_W    = 10,
    parameter int WEIGHT_W = 4
);
    logic                enable;
    logic                draw_busy;
    logic                go_key;
    logic                hit;
    logic [WEIGHT_W-1:0] hit_weight;
    logic                bomb_key;
    logic [DEG_W-1:0]    degree;
    logic [LEN_W-1:0]    rope_len;
    logic [1:0]          state;
    logic                catch_done;
    logic [WEIGHT_W-1:0] caught_weight;
    logic [1:0]          bomb_count;

    modport master (
        input  enable, draw_busy, go_key, hit, hit_weight, bomb_key,
        output degree, rope_len, state, catch_done, caught_weight, bomb_count
    );

    modport slave (
        output enable, draw_busy, go_key, hit, hit_weight, bomb_key,
        input  degree, rope_len, state, catch_done, caught_weight, bomb_count
    );
endinterface

// File: rtl/rope_hook_fsm.sv
// Gold-miner hook controller: swings, fires on a go edge, extends, retracts by weight.
// Motion updates one clock after an advance tick; catch_done pulses one clock after retraction ends.
// draw_busy=1 or enable=0 freezes all motion; key edges are still captured every clock.
//
// Ports: clock, resetn (synchronous, active-high), bus (rope_hook_if.master).
// Optional macro ROPE_BOMB_EN adds the bomb key: drops the load mid-retract, bomb_count counts down.
module rope_hook_fsm #(
    parameter int DEG_W      = 10,
    parameter int DEG_MIN    = 10,
    parameter int DEG_MAX    = 170,
    parameter int SWING_STEP = 2,
    parameter int LEN_W      = 10,
    parameter int LEN_MIN    = 20,
    parameter int LEN_MAX    = 400,
    parameter int EXT_STEP   = 4,
    parameter int RET_STEP   = 8,
    parameter int WEIGHT_W   = 4,
    parameter int BOMB_INIT  = 3
) (
    input logic         clock,
    input logic         resetn,
    rope_hook_if.master bus
);
    typedef enum logic [1:0] {SWING = 2'd0, EXTEND = 2'd1, RETRACT = 2'd2, DONE = 2'd3} state_t;

    // One spare bit on every sum so limit compares never wrap.
    localparam int SW = WEIGHT_W + LEN_W;
    localparam int XW = SW + 1;
    localparam logic [DEG_W:0]  DMIN_X  = (DEG_W+1)'(DEG_MIN);
    localparam logic [DEG_W:0]  DMAX_X  = (DEG_W+1)'(DEG_MAX);
    localparam logic [DEG_W:0]  DSTEP_X = (DEG_W+1)'(SWING_STEP);
    localparam logic [XW-1:0]   LMIN_X  = XW'(LEN_MIN);
    localparam logic [XW-1:0]   LMAX_X  = XW'(LEN_MAX);
    localparam logic [XW-1:0]   EXT_X   = XW'(EXT_STEP);
    localparam logic [SW-1:0]   RET_X   = SW'(RET_STEP);

    state_t              state_q, state_d;
    logic [DEG_W-1:0]    deg_q, deg_d;
    logic                dir_up_q, dir_up_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [WEIGHT_W-1:0] load_q, load_d;
    logic                go_q, go_pend_q, go_pend_d;
    logic                adv, go_rise, bomb_fire;
    logic [WEIGHT_W-1:0] eff_load;
    logic [SW-1:0]       ret_step;
    logic [DEG_W:0]      deg_x, deg_up;
    logic [XW-1:0]       len_x, ext_next;

    assign adv     = bus.enable & ~bus.draw_busy;
    assign go_rise = bus.go_key & ~go_q;

`ifdef ROPE_BOMB_EN
    logic       bomb_q, bomb_pend_q, bomb_pend_d;
    logic [1:0] bombs_q, bombs_d;
    logic       bomb_rise;

    assign bomb_rise = bus.bomb_key & ~bomb_q;
    assign bomb_fire = (state_q == RETRACT) & adv & bomb_pend_q;

    // An edge is only armed when dropping the load would matter and a bomb remains.
    always_comb begin
        bomb_pend_d = 1'b0;
        bombs_d     = bombs_q;
        if (state_q == RETRACT && !bomb_fire)
            bomb_pend_d = bomb_pend_q |
                          (bomb_rise & (load_q != '0) & (bombs_q != 2'd0));
        if (bomb_fire)
            bombs_d = bombs_q - 2'd1;
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            bomb_q      <= 1'b0;
            bomb_pend_q <= 1'b0;
            bombs_q     <= 2'(BOMB_INIT);
        end else begin
            bomb_q      <= bus.bomb_key;
            bomb_pend_q <= bomb_pend_d;
            bombs_q     <= bombs_d;
        end
    end

    assign bus.bomb_count = bombs_q;
`else
    logic unused_bomb;
    assign unused_bomb    = bus.bomb_key;
    assign bomb_fire      = 1'b0;
    assign bus.bomb_count = 2'd0;
`endif

    // A bomb firing this tick already retracts at full unloaded speed.
    assign eff_load = bomb_fire ? '0 : load_q;
    assign ret_step = (RET_X > SW'(eff_load)) ? (RET_X - SW'(eff_load)) : SW'(1);

    assign deg_x    = {1'b0, deg_q};
    assign deg_up   = deg_x + DSTEP_X;
    assign len_x    = XW'(len_q);
    assign ext_next = len_x + EXT_X;

    always_comb begin
        state_d  = state_q;
        deg_d    = deg_q;
        dir_up_d = dir_up_q;
        len_d    = len_q;
        load_d   = load_q;

        // Edges seen outside SWING are dropped; a pending fire is consumed by its tick.
        if (state_q != SWING || (adv && go_pend_q))
            go_pend_d = 1'b0;
        else
            go_pend_d = go_pend_q | go_rise;

        case (state_q)
            SWING: begin
                if (adv) begin
                    if (go_pend_q) begin
                        state_d = EXTEND;
                    end else if (dir_up_q) begin
                        if (deg_up >= DMAX_X) begin
                            deg_d    = DEG_W'(DMAX_X);
                            dir_up_d = 1'b0;
                        end else begin
                            deg_d = DEG_W'(deg_up);
                        end
                    end else begin
                        if (deg_x <= DMIN_X + DSTEP_X) begin
                            deg_d    = DEG_W'(DMIN_X);
                            dir_up_d = 1'b1;
                        end else begin
                            deg_d = DEG_W'(deg_x - DSTEP_X);
                        end
                    end
                end
            end
            EXTEND: begin
                if (adv) begin
                    if (bus.hit) begin
                        load_d  = bus.hit_weight;
                        state_d = RETRACT;
                    end else if (ext_next >= LMAX_X) begin
                        len_d   = LEN_W'(LMAX_X);
                        load_d  = '0;
                        state_d = RETRACT;
                    end else begin
                        len_d = LEN_W'(ext_next);
                    end
                end
            end
            RETRACT: begin
                if (adv) begin
                    if (bomb_fire)
                        load_d = '0;
                    if (len_x <= LMIN_X + XW'(ret_step)) begin
                        len_d   = LEN_W'(LMIN_X);
                        state_d = DONE;
                    end else begin
                        len_d = LEN_W'(len_x - XW'(ret_step));
                    end
                end
            end
            default: state_d = SWING;  // DONE: single clock, ungated
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q   <= SWING;
            deg_q     <= DEG_W'(DMIN_X);
            dir_up_q  <= 1'b1;
            len_q     <= LEN_W'(LMIN_X);
            load_q    <= '0;
            go_q      <= 1'b0;
            go_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deg_q     <= deg_d;
            dir_up_q  <= dir_up_d;
            len_q     <= len_d;
            load_q    <= load_d;
            go_q      <= bus.go_key;
            go_pend_q <= go_pend_d;
        end
    end

    assign bus.degree        = deg_q;
    assign bus.rope_len      = len_q;
    assign bus.state         = state_q;
    assign bus.catch_done    = (state_q == DONE);
    assign bus.caught_weight = (state_q == DONE) ? load_q : '0;
endmodule

// File: tb/tb_rope_hook_fsm.sv
module tb_rope_hook_fsm;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    rope_hook_if #(.DEG_W(10), .LEN_W(10), .WEIGHT_W(4)) bus ();

    rope_hook_fsm #(
        .DEG_W(10), .DEG_MIN(10), .DEG_MAX(170), .SWING_STEP(2),
        .LEN_W(10), .LEN_MIN(20), .LEN_MAX(400), .EXT_STEP(4), .RET_STEP(8),
        .WEIGHT_W(4), .BOMB_INIT(3)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

`ifdef ROPE_BOMB_EN
    localparam int BOMBS0 = 3;
`else
    localparam int BOMBS0 = 0;
`endif

    typedef struct {
        int    cyc;
        string name;
        int    st;
        int    deg;
        int    len;
        int    bombs;
    } snap_t;

    snap_t snap_q[$];
    int    catch_q[$];
    snap_t mon_s;
    int    mon_w;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    exp_bombs;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Expected pose after the clock edge just taken; the monitor checks it at the next negedge.
    task automatic expect_snap(input string name, input int st, input int deg, input int len);
        snap_t s;
        s.cyc   = cyc;
        s.name  = name;
        s.st    = st;
        s.deg   = deg;
        s.len   = len;
        s.bombs = exp_bombs;
        snap_q.push_back(s);
    endtask

    // Monitor: pose snapshots by cycle, catch reports whenever catch_done is high.
    always @(negedge clock) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            mon_s = snap_q.pop_front();
            total++;
            if (bus.state !== 2'(mon_s.st) || bus.degree !== 10'(mon_s.deg) ||
                bus.rope_len !== 10'(mon_s.len) || bus.bomb_count !== 2'(mon_s.bombs)) begin
                bad++;
                $display("FAIL %s: got state=%0d degree=%0d rope_len=%0d bomb_count=%0d, want state=%0d degree=%0d rope_len=%0d bomb_count=%0d",
                         mon_s.name, bus.state, bus.degree, bus.rope_len, bus.bomb_count,
                         mon_s.st, mon_s.deg, mon_s.len, mon_s.bombs);
            end
        end
        if (bus.catch_done === 1'b1) begin
            total++;
            if (catch_q.size() == 0) begin
                bad++;
                $display("FAIL catch_unexpected: caught_weight=%0d, want no catch pulse", bus.caught_weight);
            end else begin
                mon_w = catch_q.pop_front();
                if (bus.caught_weight !== 4'(mon_w)) begin
                    bad++;
                    $display("FAIL catch_weight: got %0d, want %0d", bus.caught_weight, mon_w);
                end
            end
        end else if (cyc > 2) begin
            total++;
            if (bus.catch_done !== 1'b0 || bus.caught_weight !== 4'd0) begin
                bad++;
                $display("FAIL catch_idle: catch_done=%0b caught_weight=%0d, want 0/0",
                         bus.catch_done, bus.caught_weight);
            end
        end
    end

    initial begin
        resetn         = 1'b1;
        bus.enable     = 1'b1;
        bus.draw_busy  = 1'b0;
        bus.go_key     = 1'b0;
        bus.hit        = 1'b0;
        bus.hit_weight = 4'd0;
        bus.bomb_key   = 1'b0;
        exp_bombs      = BOMBS0;

        step(2);
        expect_snap("reset", 0, 10, 20);
        resetn = 1'b0;

        // Full swing up, then reversal.
        step(80);  expect_snap("swing_top", 0, 170, 20);
        step(1);   expect_snap("swing_reverse", 0, 168, 20);

        // Fire at 50, no hit: full extension, unloaded retraction.
        step(58);
        bus.go_key = 1'b1; step(1); expect_snap("fire_deg50", 0, 50, 20);
        bus.go_key = 1'b0; step(1); expect_snap("extend_enter", 1, 50, 20);
        step(94);  expect_snap("extend_396", 1, 50, 396);
        step(1);   expect_snap("extend_max", 2, 50, 400);
        step(47);  expect_snap("retract_24", 2, 50, 24);
        catch_q.push_back(0);
        step(1);   expect_snap("done_miss", 3, 50, 20);
        step(1);   expect_snap("swing_resume", 0, 50, 20);
        step(1);   expect_snap("swing_dir_kept", 0, 48, 20);

        // Hit weight 5 at length 100: step 3.
        bus.go_key = 1'b1; step(1);
        bus.go_key = 1'b0; step(1); expect_snap("extend2_enter", 1, 46, 20);
        step(20);  expect_snap("extend2_100", 1, 46, 100);
        bus.hit = 1'b1; bus.hit_weight = 4'd5; step(1);
        bus.hit = 1'b0; expect_snap("hit5_hold", 2, 46, 100);
        catch_q.push_back(5);
        step(26);  expect_snap("retract5_22", 2, 46, 22);
        step(1);   expect_snap("done_w5", 3, 46, 20);
        step(1);   expect_snap("swing_after_w5", 0, 46, 20);

        // Freeze under draw_busy/enable, discarded go edge, then weight 12 (step 1).
        bus.go_key = 1'b1; step(1);
        bus.go_key = 1'b0; step(1);
        step(5);   expect_snap("extend3_40", 1, 44, 40);
        bus.draw_busy = 1'b1;
        bus.go_key = 1'b1; step(3);
        bus.go_key = 1'b0; step(3);
        bus.go_key = 1'b1; step(4);
        expect_snap("busy_frozen", 1, 44, 40);
        bus.go_key = 1'b0; bus.draw_busy = 1'b0;
        bus.enable = 1'b0; step(2); expect_snap("enable_low_frozen", 1, 44, 40);
        bus.enable = 1'b1;
        step(15);  expect_snap("extend3_100", 1, 44, 100);
        bus.hit = 1'b1; bus.hit_weight = 4'd12; step(1);
        bus.hit = 1'b0; expect_snap("hit12_hold", 2, 44, 100);
        catch_q.push_back(12);
        step(79);  expect_snap("retract12_21", 2, 44, 21);
        step(1);   expect_snap("done_w12", 3, 44, 20);
        step(1);   expect_snap("swing_after_w12", 0, 44, 20);
        step(2);   expect_snap("go_edge_discarded", 0, 40, 20);

        // Hit on the same tick the rope would reach LEN_MAX.
        bus.go_key = 1'b1; step(1);
        bus.go_key = 1'b0; step(1);
        step(94);  expect_snap("extend4_396", 1, 38, 396);
        bus.hit = 1'b1; bus.hit_weight = 4'd7; step(1);
        bus.hit = 1'b0; expect_snap("hit_beats_max", 2, 38, 396);
        catch_q.push_back(7);
        step(375); expect_snap("retract7_21", 2, 38, 21);
        step(1);   expect_snap("done_w7", 3, 38, 20);
        step(1);   expect_snap("swing_after_w7", 0, 38, 20);

        // Bomb edge in SWING is discarded; then weight 9 with a bomb mid-retract.
        bus.bomb_key = 1'b1; step(1);
        bus.bomb_key = 1'b0; step(1);
        bus.go_key = 1'b1; step(1);
        bus.go_key = 1'b0; step(1);
        step(20);  expect_snap("extend5_100", 1, 32, 100);
        bus.hit = 1'b1; bus.hit_weight = 4'd9; step(1);
        bus.hit = 1'b0; expect_snap("hit9_hold", 2, 32, 100);
        step(2);   expect_snap("retract9_98", 2, 32, 98);
        bus.bomb_key = 1'b1; step(1); expect_snap("bomb_edge", 2, 32, 97);
        bus.bomb_key = 1'b0;
`ifdef ROPE_BOMB_EN
        exp_bombs = 2;
        step(1);   expect_snap("bomb_fired", 2, 32, 89);
        catch_q.push_back(0);
        step(8);   expect_snap("retract_bombed_25", 2, 32, 25);
`else
        step(1);   expect_snap("bomb_ignored", 2, 32, 96);
        catch_q.push_back(9);
        step(75);  expect_snap("retract9_21", 2, 32, 21);
`endif
        step(1);   expect_snap("done_bomb", 3, 32, 20);
        step(1);   expect_snap("swing_after_bomb", 0, 32, 20);

        // Reset in the middle of a retraction.
        bus.go_key = 1'b1; step(1);
        bus.go_key = 1'b0; step(1);
        step(5);   expect_snap("extend6_40", 1, 30, 40);
        bus.hit = 1'b1; bus.hit_weight = 4'd2; step(1);
        bus.hit = 1'b0;
        step(2);   expect_snap("retract2_28", 2, 30, 28);
        resetn = 1'b1; exp_bombs = BOMBS0; step(1);
        expect_snap("reset_mid_retract", 0, 10, 20);
        resetn = 1'b0; step(1);
        expect_snap("swing_after_reset", 0, 12, 20);
        step(3);

        while (snap_q.size() > 0) begin
            mon_s = snap_q.pop_front();
            total++;
            bad++;
            $display("FAIL snap_unchecked: %s never sampled, want it checked", mon_s.name);
        end
        while (catch_q.size() > 0) begin
            mon_w = catch_q.pop_front();
            total++;
            bad++;
            $display("FAIL catch_missing: got no catch pulse, want caught_weight=%0d", mon_w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rope_hook_fsm.md
Name: rope_hook_fsm

Overview:
Parametrised hook/rope controller for the gold-miner game.
- Swings the hook angle back and forth and fires the rope on a "go" key edge.
- Extends the rope until it hits an object or reaches maximum length, then retracts it at a speed that depends on the caught object's weight.
- Drives the degree and rope_len values consumed by the renderer and the collision checker. Reports each completed catch to the scoring logic.

Parameters:
DEG_W, 10, width of degree
DEG_MIN, 10, lower swing limit (degrees)
DEG_MAX, 170, upper swing limit (degrees)
SWING_STEP, 2, degree change per enable tick
LEN_W, 10, width of rope_len
LEN_MIN, 20, idle/retracted rope length
LEN_MAX, 400, maximum extension
EXT_STEP, 4, length increase per tick while extending
RET_STEP, 8, unloaded retract speed per tick
WEIGHT_W, 4, width of object weight
BOMB_INIT, 3, initial bomb count (only with ROPE_BOMB_EN)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous reset, active-high (asserted = reset, despite the name)
enable  in  1  game tick; all motion advances only on clock edges where enable=1
draw_busy  in  1  renderer busy; while high, all motion and state transitions are frozen
go_key  in  1  level from the fire key; edge detected internally
hit  in  1  collision flag from the object checker
hit_weight  in  WEIGHT_W  weight of the hit object, sampled with hit
bomb_key  in  1  bomb key level (used only with ROPE_BOMB_EN)
degree  out  DEG_W  current hook angle
rope_len  out  LEN_W  current rope length
state  out  2  0=SWING 1=EXTEND 2=RETRACT 3=DONE
catch_done  out  1  one-cycle pulse when a retraction completes
caught_weight  out  WEIGHT_W  weight delivered; valid while catch_done=1
bomb_count  out  2  remaining bombs (reads 0 without ROPE_BOMB_EN)

Behaviour:
- Reset values: degree=DEG_MIN, direction=up, rope_len=LEN_MIN, state=SWING, catch_done=0, caught_weight=0, load=0, go_pending=0, bomb_count=BOMB_INIT (or 0 without the macro).
- Reset is honoured mid-operation and has priority over every other input.
- go_key edge detection runs on every clock, independent of enable and draw_busy.
  - A rising edge sets go_pending.
  - go_pending clears on the advance tick that consumes it.
  - go_pending also clears whenever state != SWING, so edges seen outside SWING are discarded.
- Advance tick = enable=1 and draw_busy=0. Registered state, degree and rope_len change only on advance ticks. catch_done is the only exception (see DONE).
- SWING:
  - Direction up: degree += SWING_STEP. If the result is >= DEG_MAX, clamp to DEG_MAX and reverse direction.
  - Direction down: the mirror case against DEG_MIN.
  - If go_pending=1 at the tick: go to EXTEND, degree held, and no swing step is applied on that tick.
- EXTEND:
  - rope_len += EXT_STEP.
  - If hit=1: latch load=hit_weight, go to RETRACT, and rope_len is not incremented on that tick.
  - Else if the next length would be >= LEN_MAX: rope_len=LEN_MAX, load=0, go to RETRACT.
  - hit wins over reaching LEN_MAX on the same tick.
- RETRACT:
  - step = RET_STEP - load when RET_STEP - load >= 1, otherwise step = 1. Compute at WEIGHT_W+LEN_W width with no underflow.
  - rope_len -= step.
  - If the next length would be <= LEN_MIN: rope_len=LEN_MIN, go to DONE.
  - hit is ignored in this state.
- DONE:
  - Lasts exactly one clock and is not gated by enable.
  - catch_done=1 and caught_weight=load for that cycle.
  - Next clock: state=SWING, catch_done=0, caught_weight=0.
  - Swing direction and degree resume from their pre-fire values.
- All arithmetic saturates. degree and rope_len never leave [DEG_MIN,DEG_MAX] and [LEN_MIN,LEN_MAX].

Optional Feature:
Macro ROPE_BOMB_EN.
- Defined:
  - A bomb_key rising edge (edge-detected like go_key) during RETRACT, with load != 0 and bomb_count != 0, acts on the next advance tick.
  - On that tick: load=0, bomb_count -= 1, and the retract step for that tick is already RET_STEP.
  - Edges under any other condition are discarded.
  - catch_done later reports weight 0.
- Not defined: bomb_key is ignored, bomb_count is tied to 0, and no bomb logic is synthesised.

Test Plan:
- Reset, then 80 advance ticks -> degree goes 10→170 in steps of 2, state=0. Tick 81 -> degree=168.
- Fire go at degree=50, no hit -> state=1 next tick. rope_len=400 after 95 ticks, then state=2. 48 ticks later rope_len=20. Then one catch_done pulse with caught_weight=0, and state returns to 0 with degree=50.
- Fire, hit with weight 5 when rope_len=100 -> retract step 3. rope_len reaches 20 after 27 ticks. catch_done pulses with caught_weight=5.
- Hit with weight 12 -> step 1, 80 ticks to retract from length 100. hit and LEN_MAX on the same tick -> load is latched from the hit.
- draw_busy=1 for 10 cycles during EXTEND -> rope_len and state unchanged. A go edge during that time is discarded. Reset asserted mid-RETRACT -> all reset values the next clock.
- ROPE_BOMB_EN defined: weight 9 caught, bomb pressed -> bomb_count 3→2, step becomes 8, caught_weight=0. With the macro undefined, the same stimulus yields step 1 and caught_weight=9.
